// File: rtl/cpsr_flag_unit.sv
// CPSR/SPSR state for the Thumb core: NZCV update, MSR writes, exception entry/return.
// Define SPSR_BANK_EN for five mode-banked SPSRs; otherwise one shared SPSR.
module cpsr_flag_unit #(
    parameter logic [31:0] RESET_CPSR = 32'h0000_00F3,
    parameter logic [4:0]  USER_MODE  = 5'b10000
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [2:0]  FLAG_OP,
    input  logic [31:0] ALU_RES,
    input  logic        ALU_A_MSB,
    input  logic        ALU_B_MSB,
    input  logic        ALU_COUT,
    input  logic        SHIFT_COUT,
    input  logic        PSR_WE,
    input  logic        PSR_SEL,
    input  logic [3:0]  PSR_MASK,
    input  logic [31:0] PSR_WDATA,
    input  logic        EXC_REQ,
    input  logic [4:0]  EXC_MODE,
    input  logic        EXC_RET,
    output logic [31:0] CPSR,
    output logic [31:0] SPSR
);

    localparam logic [4:0] SysMode = 5'b11111;
    localparam logic [4:0] FiqMode = 5'b10001;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0] cpsr_q, cpsr_d;
    logic [31:0] cpsr_fl, cpsr_exc, spsr_cur;
    logic [3:0]  nzcv;
    logic [3:0]  cpsr_mask;
    logic        res_zero, is_user, spsr_wr_ok;

    assign res_zero   = (ALU_RES == 32'd0);
    assign is_user    = (cpsr_q[4:0] == USER_MODE);
    assign spsr_wr_ok = !is_user && (cpsr_q[4:0] != SysMode);
    // User mode may only touch the flag byte.
    assign cpsr_mask  = is_user ? {PSR_MASK[3], 3'b000} : PSR_MASK;

    always_comb begin
        nzcv = cpsr_q[31:28];
        case (FLAG_OP)
            3'd1, 3'd5: nzcv[3:2] = {ALU_RES[31], res_zero};
            3'd2:       nzcv[3:1] = {ALU_RES[31], res_zero, SHIFT_COUT};
            3'd3: nzcv = {ALU_RES[31], res_zero, ALU_COUT,
                          (ALU_A_MSB == ALU_B_MSB) && (ALU_RES[31] != ALU_A_MSB)};
            3'd4: nzcv = {ALU_RES[31], res_zero, ALU_COUT,
                          (ALU_A_MSB != ALU_B_MSB) && (ALU_RES[31] != ALU_A_MSB)};
            default: ;
        endcase
    end

    assign cpsr_fl  = {nzcv, cpsr_q[27:0]};
    assign cpsr_exc = {cpsr_q[31:8], 1'b1, (EXC_MODE == FiqMode) ? 1'b1 : cpsr_q[6],
                       cpsr_q[5], EXC_MODE};

`ifdef SPSR_BANK_EN
    // {hit, index} of the banked SPSR for a mode; hit=0 for user/system/undefined.
    function automatic logic [3:0] bank_of(input logic [4:0] mode);
        case (mode)
            5'b10001: return 4'b1000;
            5'b10010: return 4'b1001;
            5'b10011: return 4'b1010;
            5'b10111: return 4'b1011;
            5'b11011: return 4'b1100;
            default:  return 4'b0000;
        endcase
    endfunction

    logic [31:0] spsr_q [5];
    logic [31:0] spsr_d [5];
    logic [3:0]  cur_bank, exc_bank;

    assign cur_bank = bank_of(cpsr_q[4:0]);
    assign exc_bank = bank_of(EXC_MODE);
    assign spsr_cur = cur_bank[3] ? spsr_q[cur_bank[2:0]] : 32'd0;

    always_comb begin
        cpsr_d = cpsr_fl;
        spsr_d = spsr_q;
        if (EXC_REQ) begin
            cpsr_d = cpsr_exc;
            if (exc_bank[3]) spsr_d[exc_bank[2:0]] = cpsr_fl;
        end else if (EXC_RET) begin
            cpsr_d = cur_bank[3] ? spsr_q[cur_bank[2:0]] : cpsr_q;
        end else if (PSR_WE) begin
            if (!PSR_SEL) begin
                cpsr_d = merge_bytes(cpsr_q, PSR_WDATA, cpsr_mask);
            end else if (spsr_wr_ok && cur_bank[3]) begin
                spsr_d[cur_bank[2:0]] = merge_bytes(spsr_q[cur_bank[2:0]], PSR_WDATA, PSR_MASK);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cpsr_q <= RESET_CPSR;
            for (int i = 0; i < 5; i++) spsr_q[i] <= 32'd0;
        end else begin
            cpsr_q <= cpsr_d;
            for (int i = 0; i < 5; i++) spsr_q[i] <= spsr_d[i];
        end
    end
`else
    logic [31:0] spsr_q, spsr_d;

    assign spsr_cur = spsr_q;

    always_comb begin
        cpsr_d = cpsr_fl;
        spsr_d = spsr_q;
        if (EXC_REQ) begin
            cpsr_d = cpsr_exc;
            spsr_d = cpsr_fl;
        end else if (EXC_RET) begin
            cpsr_d = spsr_q;
        end else if (PSR_WE) begin
            if (!PSR_SEL) begin
                cpsr_d = merge_bytes(cpsr_q, PSR_WDATA, cpsr_mask);
            end else if (spsr_wr_ok) begin
                spsr_d = merge_bytes(spsr_q, PSR_WDATA, PSR_MASK);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cpsr_q <= RESET_CPSR;
            spsr_q <= 32'd0;
        end else begin
            cpsr_q <= cpsr_d;
            spsr_q <= spsr_d;
        end
    end
`endif

    assign CPSR = cpsr_q;
    assign SPSR = spsr_cur;

endmodule

// File: tb/tb_cpsr_flag_unit.sv
// Directed bench for cpsr_flag_unit with hand-computed expected CPSR/SPSR values.
module tb_cpsr_flag_unit;

    logic        clk, n_reset;
    logic [2:0]  flag_op;
    logic [31:0] alu_res;
    logic        a_msb, b_msb, alu_cout, shift_cout;
    logic        psr_we, psr_sel;
    logic [3:0]  psr_mask;
    logic [31:0] psr_wdata;
    logic        exc_req, exc_ret;
    logic [4:0]  exc_mode;
    logic [31:0] cpsr, spsr;

    int n_tests = 0;
    int n_fail  = 0;

    cpsr_flag_unit dut (
        .CLK        (clk),
        .nRESET     (n_reset),
        .FLAG_OP    (flag_op),
        .ALU_RES    (alu_res),
        .ALU_A_MSB  (a_msb),
        .ALU_B_MSB  (b_msb),
        .ALU_COUT   (alu_cout),
        .SHIFT_COUT (shift_cout),
        .PSR_WE     (psr_we),
        .PSR_SEL    (psr_sel),
        .PSR_MASK   (psr_mask),
        .PSR_WDATA  (psr_wdata),
        .EXC_REQ    (exc_req),
        .EXC_MODE   (exc_mode),
        .EXC_RET    (exc_ret),
        .CPSR       (cpsr),
        .SPSR       (spsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flag_op = 3'd0; alu_res = 32'd0; a_msb = 1'b0; b_msb = 1'b0;
        alu_cout = 1'b0; shift_cout = 1'b0;
        psr_we = 1'b0; psr_sel = 1'b0; psr_mask = 4'd0; psr_wdata = 32'd0;
        exc_req = 1'b0; exc_ret = 1'b0; exc_mode = 5'd0;
    endtask

    // Clock in the currently driven inputs, then return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic alu(input logic [2:0] op, input logic [31:0] r, input logic a, input logic b,
                       input logic co, input logic sc);
        flag_op = op; alu_res = r; a_msb = a; b_msb = b; alu_cout = co; shift_cout = sc;
        step();
    endtask

    task automatic msr(input logic sel, input logic [3:0] mask, input logic [31:0] wd);
        psr_we = 1'b1; psr_sel = sel; psr_mask = mask; psr_wdata = wd;
        step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        #2;
        check_eq("async_rst_cpsr", cpsr, 32'h0000_00F3);
        check_eq("async_rst_spsr", spsr, 32'h0000_0000);
        #1;
        n_reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        n_reset = 1'b0;
        #12;
        check_eq("reset_cpsr", cpsr, 32'h0000_00F3);
        check_eq("reset_spsr", spsr, 32'h0000_0000);
        @(negedge clk);
        n_reset = 1'b1;
        step();
        check_eq("post_release_cpsr", cpsr, 32'h0000_00F3);

        alu(3'd3, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("add_zcv", cpsr, 32'h7000_00F3);
        alu(3'd4, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("sub_nv", cpsr, 32'h9000_00F3);
        alu(3'd3, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        alu(3'd1, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("logic_holds_cv", cpsr, 32'hB000_00F3);
        alu(3'd2, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("shift_carry", cpsr, 32'h5000_00F3);
        alu(3'd5, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("mul_nz_only", cpsr, 32'h9000_00F3);
        alu(3'd6, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("op6_none", cpsr, 32'h9000_00F3);
        alu(3'd4, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("sub_no_ovf", cpsr, 32'h2000_00F3);

        // SPSR write in SVC alongside a flag update: both take effect.
        flag_op = 3'd1; alu_res = 32'd0;
        msr(1'b1, 4'b1111, 32'hA5A5_A5A5);
        check_eq("msr_spsr", spsr, 32'hA5A5_A5A5);
        check_eq("msr_spsr_flags", cpsr, 32'h6000_00F3);

        // CPSR MSR wins over a same-cycle flag update.
        flag_op = 3'd3; alu_res = 32'd0;
        msr(1'b0, 4'b1001, 32'h1234_5613);
        check_eq("msr_cpsr_wins", cpsr, 32'h1200_0013);

        msr(1'b0, 4'b1111, 32'h6000_0010);
        check_eq("enter_user", cpsr, 32'h6000_0010);
        msr(1'b0, 4'b1001, 32'hF000_00D3);
        check_eq("user_msr_flags_only", cpsr, 32'hF000_0010);
        msr(1'b1, 4'b1111, 32'h0000_0000);
`ifdef SPSR_BANK_EN
        check_eq("user_spsr_protected", spsr, 32'h0000_0000);
`else
        check_eq("user_spsr_protected", spsr, 32'hA5A5_A5A5);
`endif

        do_reset();
        msr(1'b0, 4'b1111, 32'h2000_0033);
        check_eq("svc_setup", cpsr, 32'h2000_0033);
        flag_op = 3'd1; alu_res = 32'd0;
        exc_req = 1'b1; exc_mode = 5'b10010; exc_ret = 1'b1;
        psr_we = 1'b1; psr_sel = 1'b0; psr_mask = 4'b1111; psr_wdata = 32'h0;
        step();
        check_eq("exc_irq_spsr", spsr, 32'h6000_0033);
        check_eq("exc_irq_cpsr", cpsr, 32'h2000_00B2);
        flag_op = 3'd3; alu_res = 32'd0; exc_ret = 1'b1;
        step();
        check_eq("exc_ret_cpsr", cpsr, 32'h6000_0033);
        exc_req = 1'b1; exc_mode = 5'b10001;
        step();
        check_eq("exc_fiq_cpsr", cpsr, 32'h6000_00F1);
        check_eq("exc_fiq_spsr", spsr, 32'h6000_0033);
        exc_ret = 1'b1;
        step();
        check_eq("fiq_ret_cpsr", cpsr, 32'h6000_0033);

`ifdef SPSR_BANK_EN
        do_reset();
        exc_req = 1'b1; exc_mode = 5'b10010;
        step();
        check_eq("bank_irq_cpsr", cpsr, 32'h0000_00F2);
        check_eq("bank_irq_spsr", spsr, 32'h0000_00F3);
        msr(1'b0, 4'b0001, 32'h0000_00D1);
        check_eq("bank_to_fiq", cpsr, 32'h0000_00D1);
        check_eq("bank_fiq_empty", spsr, 32'h0000_0000);
        msr(1'b1, 4'b1111, 32'h1234_5678);
        check_eq("bank_fiq_write", spsr, 32'h1234_5678);
        msr(1'b0, 4'b0001, 32'h0000_00D2);
        check_eq("bank_irq_kept", spsr, 32'h0000_00F3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
